// File: rtl/tinytester_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tinytester_phase_sequencer
// Purpose  : Timing engine between the tinytester register block and the DUT
//            pins. Runs a programmed number of test cycles, each split into
//            four phases P0..P3 of (phase_len+1) clocks. Drives pins from the
//            shadowed data/oe/phase masks, captures pins_i on the last clock
//            of STROBE_PHASE, and reports status plus a one-clock done
//            interrupt.
// Ports    : WBs_CLK_i     - sequencer clock
//            WBs_RST_n_i   - asynchronous reset, active-low
//            control_i     - [0] start, [1] continuous, [2] abort,
//                            [15:8] phase_len, [31:16] num_cycles
//            dataout_i     - drive data
//            oe_i          - per-pin output enable (1 = output)
//            active_on_p*_i- per-phase drive masks
//            pins_i        - DUT pin input values
//            pins_o        - registered pin drive values
//            pins_oe_o     - registered pin output enables
//            datain_o      - last captured pins_i
//            status_o      - [0] busy, [1] done, [2] mismatch, [3] aborted,
//                            [31:16] cycles_completed
//            interrupt_o   - one-clock done pulse
// Options  : TINYTESTER_MISMATCH_EN - when defined, input pins are compared
//            against the shadowed drive data at every strobe; the first
//            difference sets mismatch and ends the run.
// Revision : 1.0 - initial release
// ============================================================================
module tinytester_phase_sequencer #(
  parameter int PIN_W        = 32,
  parameter int STROBE_PHASE = 2,
  parameter int CYC_CNT_W    = 16
) (
  input  logic             WBs_CLK_i,
  input  logic             WBs_RST_n_i,
  input  logic [31:0]      control_i,
  input  logic [PIN_W-1:0] dataout_i,
  input  logic [PIN_W-1:0] oe_i,
  input  logic [PIN_W-1:0] active_on_p0_i,
  input  logic [PIN_W-1:0] active_on_p1_i,
  input  logic [PIN_W-1:0] active_on_p2_i,
  input  logic [PIN_W-1:0] active_on_p3_i,
  input  logic [PIN_W-1:0] pins_i,
  output logic [PIN_W-1:0] pins_o,
  output logic [PIN_W-1:0] pins_oe_o,
  output logic [PIN_W-1:0] datain_o,
  output logic [31:0]      status_o,
  output logic             interrupt_o
);

  localparam logic [1:0] C_STROBE_PHASE = STROBE_PHASE[1:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_start_q;
  logic [7:0]             r_phase_len;
  logic [7:0]             r_pcnt;
  logic [1:0]             r_phase;
  logic [CYC_CNT_W-1:0]   r_num_cycles;
  logic [CYC_CNT_W-1:0]   r_cycles;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_mismatch;
  logic                   r_aborted;
  logic [PIN_W-1:0]       r_sh_dataout;
  logic [PIN_W-1:0]       r_sh_oe;
  logic [PIN_W-1:0]       r_sh_p0;
  logic [PIN_W-1:0]       r_sh_p1;
  logic [PIN_W-1:0]       r_sh_p2;
  logic [PIN_W-1:0]       r_sh_p3;

  logic                   w_start_evt;
  logic                   w_cont;
  logic                   w_abort;
  logic [CYC_CNT_W-1:0]   w_num_in;
  logic                   w_phase_last;
  logic                   w_cycle_end;
  logic                   w_strobe;
  logic [CYC_CNT_W-1:0]   w_cc_inc;
  logic [CYC_CNT_W-1:0]   w_cc_sat;
  logic                   w_last_cycle;
  logic                   w_miscmp;
  logic [PIN_W-1:0]       w_mask;
  logic [15:0]            w_cc_ext;
  logic                   w_unused;

  assign w_start_evt  = control_i[0] & ~r_start_q;
  assign w_cont       = control_i[1];
  assign w_abort      = control_i[2];
  assign w_num_in     = control_i[16 +: CYC_CNT_W];
  assign w_unused     = &{1'b0, control_i[7:3]};

  assign w_phase_last = (r_pcnt == r_phase_len);
  assign w_cycle_end  = (r_state == ST_RUN) && w_phase_last && (r_phase == 2'd3);
  assign w_strobe     = (r_state == ST_RUN) && w_phase_last && (r_phase == C_STROBE_PHASE);

  // Count saturates at all-ones; in continuous mode it may run that long.
  assign w_cc_inc     = r_cycles + 1'b1;
  assign w_cc_sat     = (&r_cycles) ? r_cycles : w_cc_inc;
  assign w_last_cycle = !w_cont && (w_cc_inc == r_num_cycles);

`ifdef TINYTESTER_MISMATCH_EN
  // Only pins configured as inputs are compared.
  assign w_miscmp = w_strobe && (|((pins_i ^ r_sh_dataout) & ~r_sh_oe));
`else
  assign w_miscmp = 1'b0;
`endif

  always_comb begin
    w_mask = '0;
    case (r_phase)
      2'd0:    w_mask = r_sh_p0;
      2'd1:    w_mask = r_sh_p1;
      2'd2:    w_mask = r_sh_p2;
      default: w_mask = r_sh_p3;
    endcase
  end

  always_comb begin
    w_cc_ext                 = '0;
    w_cc_ext[CYC_CNT_W-1:0]  = r_cycles;
  end

  assign status_o = {w_cc_ext, 12'd0, r_aborted, r_mismatch, r_done, r_busy};

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_evt && (w_num_in != '0)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_abort || w_miscmp || (w_cycle_end && w_last_cycle)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      r_start_q    <= 1'b0;
      r_phase_len  <= '0;
      r_pcnt       <= '0;
      r_phase      <= '0;
      r_num_cycles <= '0;
      r_cycles     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mismatch   <= 1'b0;
      r_aborted    <= 1'b0;
      r_sh_dataout <= '0;
      r_sh_oe      <= '0;
      r_sh_p0      <= '0;
      r_sh_p1      <= '0;
      r_sh_p2      <= '0;
      r_sh_p3      <= '0;
      pins_o       <= '0;
      pins_oe_o    <= '0;
      datain_o     <= '0;
      interrupt_o  <= 1'b0;
    end else begin
      r_start_q   <= control_i[0];
      interrupt_o <= 1'b0;

      // Pin drive lags the phase counter by one clock. A clock that leaves
      // RUN produces an idle drive, so pins are released as soon as the run
      // stops.
      if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
        pins_o    <= r_sh_dataout & w_mask;
        pins_oe_o <= r_sh_oe;
      end else begin
        pins_o    <= '0;
        pins_oe_o <= '0;
      end

      if (w_strobe) begin
        datain_o <= pins_i;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start_evt) begin
            r_cycles   <= '0;
            r_mismatch <= 1'b0;
            r_aborted  <= 1'b0;
            if (w_num_in != '0) begin
              r_busy       <= 1'b1;
              r_done       <= 1'b0;
              r_phase_len  <= control_i[15:8];
              r_num_cycles <= w_num_in;
              r_pcnt       <= '0;
              r_phase      <= '0;
              r_sh_dataout <= dataout_i;
              r_sh_oe      <= oe_i;
              r_sh_p0      <= active_on_p0_i;
              r_sh_p1      <= active_on_p1_i;
              r_sh_p2      <= active_on_p2_i;
              r_sh_p3      <= active_on_p3_i;
            end else begin
              // Zero-cycle run completes immediately without going busy.
              r_done      <= 1'b1;
              interrupt_o <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (w_phase_last) begin
            r_pcnt  <= '0;
            r_phase <= r_phase + 2'd1;
            // Reload shadows at the boundary into P0 so a cycle in progress
            // never sees a software rewrite.
            if (r_phase == 2'd3) begin
              r_sh_dataout <= dataout_i;
              r_sh_oe      <= oe_i;
              r_sh_p0      <= active_on_p0_i;
              r_sh_p1      <= active_on_p1_i;
              r_sh_p2      <= active_on_p2_i;
              r_sh_p3      <= active_on_p3_i;
            end
          end else begin
            r_pcnt <= r_pcnt + 8'd1;
          end

          if (w_cycle_end) begin
            r_cycles <= w_cc_sat;
          end

          if (w_miscmp) begin
            r_mismatch <= 1'b1;
          end

          if (w_state_nxt == ST_DONE) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            interrupt_o <= 1'b1;
            if (w_abort) begin
              r_aborted <= 1'b1;
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tinytester_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tinytester_phase_sequencer
// Purpose  : Directed self-checking bench for tinytester_phase_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tinytester_phase_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] control;
  logic [31:0] dataout;
  logic [31:0] oe;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] pins_in;
  logic [31:0] pins_out;
  logic [31:0] pins_oe;
  logic [31:0] datain;
  logic [31:0] status;
  logic        irq;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pins;
    logic [31:0] oe;
    logic        busy;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];

  tinytester_phase_sequencer #(
    .PIN_W        (32),
    .STROBE_PHASE (2),
    .CYC_CNT_W    (16)
  ) dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_n_i    (rst_n),
    .control_i      (control),
    .dataout_i      (dataout),
    .oe_i           (oe),
    .active_on_p0_i (p0),
    .active_on_p1_i (p1),
    .active_on_p2_i (p2),
    .active_on_p3_i (p3),
    .pins_i         (pins_in),
    .pins_o         (pins_out),
    .pins_oe_o      (pins_oe),
    .datain_o       (datain),
    .status_o       (status),
    .interrupt_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   irq_cnt;
    exp_t e;

    rst_n   = 1'b0;
    control = '0;
    dataout = '0;
    oe      = '0;
    p0 = '0; p1 = '0; p2 = '0; p3 = '0;
    pins_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pins",   pins_out, 32'h0);
    check("rst_oe",     pins_oe,  32'h0);
    check("rst_status", status,   32'h0);
    check("rst_datain", datain,   32'h0);
    check("rst_irq",    {31'd0, irq}, 32'h0);
    rst_n = 1'b1;
    step();

    // ---- Reset in the middle of a run ----
    dataout = 32'hFF; oe = 32'hFF; p0 = 32'hFF;
    control = 32'h0004_0001;
    step(); step(); step();
    check("mid_oe_before", pins_oe, 32'hFF);
    check("mid_busy", status & 32'h1, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_oe",     pins_oe,  32'h0);
    check("arst_status", status,   32'h0);
    control = '0;
    step();
    rst_n = 1'b1;
    step(); step();
    check("post_rst_status", status,  32'h0);
    check("post_rst_oe",     pins_oe, 32'h0);

    // ---- 3 cycles, phase_len 0, P1 mask only ----
    dataout = 32'hA5; oe = 32'hFF;
    p0 = 32'h0; p1 = 32'h0F; p2 = 32'h0; p3 = 32'h0;
    pins_in = 32'h5A;
    for (int k = 1; k <= 14; k++) begin
      e.pins = (k == 3 || k == 7 || k == 11) ? 32'h05 : 32'h0;
      e.oe   = (k >= 2 && k <= 12) ? 32'hFF : 32'h0;
      e.busy = (k <= 12);
      e.irq  = (k == 13);
      sb_q.push_back(e);
    end
    control = 32'h0003_0001;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) control = '0;
      e = sb_q.pop_front();
      check($sformatf("run3_pins_k%0d", k), pins_out, e.pins);
      check($sformatf("run3_oe_k%0d", k),   pins_oe,  e.oe);
      check($sformatf("run3_busy_k%0d", k), {31'd0, status[0]}, {31'd0, e.busy});
      check($sformatf("run3_irq_k%0d", k),  {31'd0, irq},       {31'd0, e.irq});
    end
    check("run3_status", status, 32'h0003_0002);
    check("run3_datain", datain, 32'h5A);

    // ---- Capture on the last clock of P2 (phase_len 3, 1 cycle) ----
    pins_in = 32'h11;
    control = 32'h0001_0301;
    step();
    control = '0;
    repeat (11) step();
    check("cap_pre", datain, 32'h5A);
    pins_in = 32'h22;
    step();
    check("cap_strobe", datain, 32'h22);
    repeat (3) step();
    check("cap_busy", status & 32'h1, 32'h1);
    step();
    check("cap_status", status, 32'h0001_0002);
    check("cap_irq", {31'd0, irq}, 32'h1);
    pins_in = 32'h77;
    step(); step();
    check("cap_hold", datain, 32'h22);

    // ---- Continuous run aborted in cycle 5, P1 ----
    control = 32'h0002_0003;
    step();
    control = 32'h0002_0002;
    repeat (9) step();
    check("cont_past_num", status, 32'h0002_0001);
    repeat (8) step();
    check("cont_oe_before_abort", pins_oe, 32'hFF);
    control = 32'h0002_0006;
    step();
    check("abort_status", status, 32'h0004_000A);
    check("abort_oe", pins_oe, 32'h0);
    check("abort_irq", {31'd0, irq}, 32'h1);
    control = '0;
    step();
    check("abort_irq_off", {31'd0, irq}, 32'h0);
    check("abort_status_hold", status, 32'h0004_000A);

    // ---- Start held high: exactly one run ----
    irq_cnt = 0;
    control = 32'h0002_0001;
    for (int k = 0; k < 40; k++) begin
      step();
      if (irq) irq_cnt++;
    end
    check("held_irq_count", irq_cnt, 32'd1);
    check("held_status", status, 32'h0002_0002);
    control = '0;
    step();

    // ---- Zero-cycle start ----
    control = 32'h0000_0001;
    step();
    check("zero_status", status, 32'h0000_0002);
    check("zero_irq", {31'd0, irq}, 32'h1);
    control = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("zero_idle_k%0d", k), status, 32'h0000_0002);
      check($sformatf("zero_irq_off_k%0d", k), {31'd0, irq}, 32'h0);
    end

    // ---- Input pins differing from expected data ----
    oe = 32'h0; dataout = 32'h3C; pins_in = 32'h3D;
    control = 32'h0002_0001;
    step();
    control = '0;
`ifdef TINYTESTER_MISMATCH_EN
    step(); step(); step();
    check("mis_status", status, 32'h0000_0006);
    check("mis_irq", {31'd0, irq}, 32'h1);
    check("mis_datain", datain, 32'h3D);
`else
    repeat (8) step();
    check("nomis_status", status, 32'h0002_0002);
    check("nomis_irq", {31'd0, irq}, 32'h1);
    check("nomis_datain", datain, 32'h3D);
`endif
    step();
    check("final_irq_off", {31'd0, irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tinytester_phase_sequencer.md
Name: tinytester_phase_sequencer

Overview:
- Timing engine between the tinytester register block and the DUT pins.
- Runs a programmed number of test cycles, each split into four phases P0..P3.
- Drives pins from `dataout`, gated by the per-phase active masks and `oe`.
- Captures DUT pin values at a strobe phase and returns status, captured data and a done interrupt to the register block.

Parameters:
- `PIN_W`, 32, number of tester pins.
- `STROBE_PHASE`, 2, phase (0..3) whose last clock samples `pins_i`.
- `CYC_CNT_W`, 16, width of the cycle counter; must be ≤16.

Ports:
- `WBs_CLK_i`  in  1  sequencer clock (Wishbone FPGA clock).
- `WBs_RST_n_i`  in  1  asynchronous reset, active-low.
- `control_i`  in  32  [0] start, [1] continuous, [2] abort, [15:8] phase_len, [31:16] num_cycles.
- `dataout_i`  in  PIN_W  drive data from the register block.
- `oe_i`  in  PIN_W  per-pin output enable (1 = output).
- `active_on_p0_i` .. `active_on_p3_i`  in  PIN_W each  per-phase drive masks.
- `pins_i`  in  PIN_W  DUT pin input values.
- `pins_o`  out  PIN_W  pin drive values.
- `pins_oe_o`  out  PIN_W  pin output enables.
- `datain_o`  out  PIN_W  last captured `pins_i`; feeds the DATAIN register.
- `status_o`  out  32  [0] busy, [1] done, [2] mismatch, [3] aborted, [31:16] cycles_completed.
- `interrupt_o`  out  1  one-clock done pulse.

Behaviour:
- Reset (`WBs_RST_n_i` = 0, asynchronous): all of the following go to 0.
  - Outputs `pins_o`, `pins_oe_o`, `datain_o`, `status_o`, `interrupt_o`.
  - Internal state: FSM to IDLE, all counters, shadow registers, `start_q`.
- Start detect: `start_q` registers `control_i[0]`. `start_evt = control_i[0] & ~start_q`. A level held high does not retrigger.
- FSM states:
  - IDLE: `start_evt` with `num_cycles ≠ 0` → RUN. With `num_cycles = 0`, stay in IDLE, set done, pulse the interrupt.
  - RUN: step through P0..P3. Each phase lasts `phase_len + 1` clocks (`phase_len = 0` gives 1 clock per phase; a cycle is `4*(phase_len+1)` clocks).
  - DONE: lasts one clock; pulses `interrupt_o`, then → IDLE.
- Entering RUN:
  - Clear `cycles_completed`, done, mismatch and aborted; set busy.
  - Latch `phase_len` and `num_cycles`.
  - Load the shadow copies of `dataout_i`, `oe_i` and `active_on_p*_i`.
- First P0 clock is the clock after `start_evt`.
- Shadow reload happens on the first clock of every P0, so software may rewrite data between cycles without glitching a cycle in progress.
- Pin drive in phase k, registered (one clock after the phase counter):
  - `pins_o = shadow_dataout & shadow_active_pk`.
  - `pins_oe_o = shadow_oe`.
- Pin drive in IDLE/DONE: `pins_o = 0`, `pins_oe_o = 0`.
- Capture: on the last clock of `STROBE_PHASE`, `datain_o <= pins_i`. It holds until the next capture.
- Cycle end (last clock of P3):
  - `cycles_completed` increments, saturating at all-ones.
  - If `cycles_completed + 1 == num_cycles` and continuous = 0 → DONE.
  - If continuous = 1, run indefinitely; `num_cycles` is ignored.
- Abort: `control_i[2] = 1` in RUN → DONE on the next clock, sets aborted. A partial cycle does not count. No capture occurs unless the abort clock itself is the strobe clock.
- `start_evt` during RUN/DONE is ignored.
- DONE exit: busy clears; done stays set until the next accepted start.
- Simultaneous abort and cycle end on the same clock: abort wins, aborted = 1, and the count still increments.
- `interrupt_o` fires exactly once per run, including zero-cycle and aborted runs.

Optional Feature:
- Macro: `TINYTESTER_MISMATCH_EN`.
- Defined: at each strobe, input pins (`shadow_oe = 0`) are compared with `shadow_dataout` as expected values.
  - Any bit difference sets mismatch (`status_o[2]`), sticky until the next start.
  - The first mismatch also pulses `interrupt_o` immediately and ends the run as DONE.
- Undefined: no comparator is built; `status_o[2]` is tied 0.

Test Plan:
- Reset mid-RUN (assert `WBs_RST_n_i` low) → all outputs 0 within the same clock edge; FSM in IDLE after release.
- Start with `control_i = 0x0003_0001` (phase_len 0, 3 cycles), `dataout = 0xA5`, `oe = 0xFF`, p1 mask `0x0F`, others 0:
  - `pins_o = 0x05` during P1 only;
  - busy for 12 clocks;
  - `status_o = 0x0003_0002` afterwards;
  - one interrupt pulse.
- `phase_len = 3`, `num_cycles = 1`, `pins_i` toggled `0x11` → `0x22` on the 12th clock (last clock of P2) → `datain_o = 0x22`.
- Continuous with abort asserted on cycle 5, P1 → aborted = 1, `cycles_completed = 4`, `pins_oe_o = 0` next clock.
- Start held high for 40 clocks with `num_cycles = 2` → exactly one run, interrupt once; `num_cycles = 0` → done plus interrupt with busy never set.
- With `TINYTESTER_MISMATCH_EN`: `oe = 0x00`, `dataout = 0x3C`, `pins_i = 0x3D` → mismatch = 1 and run ends after the first strobe.
